// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: a - b - bin over NIBBLES cycles, one 4-bit
// carry-lookahead slice per cycle, with valid/ready handshakes on both sides.
module nibble_serial_sub #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   bin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   bout,
   output logic                   zero,
   output logic                   ovf,
   output logic [1:0]             dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; in_ready is high only in IDLE, out_valid only in DONE.
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          c_r;

   logic [3:0]    an;
   logic [3:0]    bn;
   logic [3:0]    g;
   logic [3:0]    p;
   logic [3:0]    d;
   logic [4:0]    c;
   logic [W-1:0]  diff_nxt;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign dbg_state = state;

   // Subtraction as a + ~b + ~bin; carries are fully flattened per slice.
   always_comb begin
      an   = a_r[{k, 2'b00} +: 4];
      bn   = ~b_r[{k, 2'b00} +: 4];
      g    = an & bn;
      p    = an ^ bn;
      c[0] = c_r;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      d    = p ^ c[3:0];
      diff_nxt = diff;
      diff_nxt[{k, 2'b00} +: 4] = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         k     <= '0;
         a_r   <= '0;
         b_r   <= '0;
         c_r   <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  c_r   <= ~bin;
                  k     <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               diff <= diff_nxt;
               c_r  <= c[4];
               if (k == K_LAST) begin
                  // Flags are derived from the completed result in the same edge.
                  bout  <= ~c[4];
                  zero  <= (diff_nxt == '0);
                  ovf   <= (a_r[W-1] != b_r[W-1]) && (diff_nxt[W-1] != a_r[W-1]);
                  k     <= '0;
                  state <= S_DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub: directed corner cases, back-pressure, reset
// abort, then randomized operands against an integer-arithmetic reference.
module tb_nibble_serial_sub;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;
   logic         ovf;
   logic [1:0]   dbg_state;

   int n_vec = 0;
   int n_err = 0;

   nibble_serial_sub #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain integer subtraction, unsigned and signed views
   task automatic ref_sub(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                          output logic [W-1:0] rd, output logic rb, output logic rz,
                          output logic ro);
      longint ua, ub, sa, sb, r, sr;
      ua = longint'(ma);
      ub = longint'(mb);
      r  = ua - ub - longint'(mbin);
      rd = r[W-1:0];
      rb = (ua < ub + longint'(mbin));
      rz = (rd == '0);
      sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
      sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
      sr = sa - sb - longint'(mbin);
      ro = (sr < -(longint'(1) << (W-1))) || (sr > (longint'(1) << (W-1)) - 1);
   endtask

   // driver: called and returns at posedge+1
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
   endtask

   // full transaction: accept, latency, result, stall, handshake
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input int stall, input bit stall_checks);
      logic [W-1:0] ed;
      logic eb, ez, eo;
      int lat = 0;
      ref_sub(ta, tb, tbin, ed, eb, ez, eo);
      send(ta, tb, tbin);
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(NIBBLES));
      check("diff", 32'(diff), 32'(ed));
      check("bout", 32'(bout), 32'(eb));
      check("zero", 32'(zero), 32'(ez));
      check("ovf",  32'(ovf),  32'(eo));
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         if (stall_checks) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         end
         @(posedge clk); #1;
         if (stall_checks) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_diff", 32'(diff), 32'(ed));
            check("hold_flags", {29'd0, bout, zero, ovf}, {29'd0, eb, ez, eo});
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (stall_checks) begin
         check("post_idle", 32'(in_ready), 32'd1);
         check("post_diff_kept", 32'(diff), 32'(ed));
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      #12;
      check("rst_in_ready",  32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outs", {15'd0, diff, bout, zero, ovf}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
      check("v30", {15'd0, diff, bout, zero, ovf}, {15'd0, 16'h1000, 3'b000});
      run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
      check("v31", {15'd0, diff, bout, zero, ovf}, {15'd0, 16'hFFFF, 3'b100});
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
      check("v32a", {15'd0, diff, bout, zero, ovf}, {15'd0, 16'h7FFF, 3'b001});
      run_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0);
      check("v32b", {15'd0, diff, bout, zero, ovf}, {15'd0, 16'h0000, 3'b010});

      // back-pressure with new operands offered while DONE
      run_op(16'hA5A5, 16'h5A5A, 1'b1, 3, 1'b1);

      // reset two cycles into CALC
      send(16'h1234, 16'h4321, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready",  32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_outs", {15'd0, diff, bout, zero, ovf}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_resume_ready", 32'(in_ready), 32'd1);
      run_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);
      check("v34", 32'(diff), 32'h00F0);

      // randomized operands with random back-pressure
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         logic rbin;
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = '0;
            2: rb = {W{1'b1}};
            default: ;
         endcase
         run_op(ra, rb, rbin, $urandom_range(0, 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
